nrzi_rx_unstuff: RTL and testbench
==================================

Name: nrzi_rx_unstuff

Overview:
Parametrised USB receive-path NRZI decoder with bit unstuffing and stuff-error detection. Sits between the edge-detect/timer block, which supplies shift_enable and eop, and the receive shift register. It emits one decoded data bit per accepted sample, suppresses stuffed bits, and flags stuffing violations. Stuff run length and idle line level are configurable so the same block serves full-speed USB and other NRZI links.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which one stuffed 0 is expected (legal range 2..15)
IDLE_LEVEL, 1'b1, line level held as the "previous" level at reset and after EOP (J state for full-speed)
CNT_W, 4, width of the ones-run counter; must satisfy 2**CNT_W > STUFF_LEN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
d_plus  input  1  synchronised D+ line level
shift_enable  input  1  one-cycle strobe: sample d_plus this cycle
eop  input  1  end-of-packet detected; qualifies shift_enable
bit_out  output  1  decoded data bit, valid when bit_valid=1
bit_valid  output  1  one-cycle strobe: bit_out holds a real (non-stuffed) data bit
stuff_drop  output  1  one-cycle strobe: a stuffed bit was removed this cycle
stuff_err  output  1  one-cycle strobe: 1 received where a stuffed 0 was required
rx_err_hold  output  1  level: stays high from stuff_err until next eop sample

Behaviour:
- Reset (rst high, async): prev_lvl=IDLE_LEVEL, ones_cnt=0, state=RUN; all outputs 0.
- Accepted sample: shift_enable=1 and eop=0. Decoded bit dec = (d_plus == prev_lvl) ? 1 : 0 (no transition = 1). prev_lvl <= d_plus.
- All outputs are registered; they assert on the clock edge after the sample cycle (latency 1). Strobes last exactly one cycle.
- shift_enable=0: no state change; strobes deassert.
- State machine:
  - RUN: on an accepted sample, bit_out<=dec and bit_valid<=1. dec=1: ones_cnt+1; on reaching STUFF_LEN, go to STUFF. dec=0: ones_cnt<=0.
  - STUFF: the next accepted sample is the stuff bit and never sets bit_valid. dec=0: stuff_drop<=1, ones_cnt<=0, go to RUN. dec=1: stuff_err<=1, rx_err_hold<=1, go to ERR.
  - ERR: accepted samples are decoded and prev_lvl is tracked, but bit_valid stays 0. Leave ERR only on eop.
- EOP sample (shift_enable=1 and eop=1), from any state: prev_lvl<=IDLE_LEVEL, ones_cnt<=0, state<=RUN, rx_err_hold<=0, no bit_valid, no stuff strobes.
- eop=1 with shift_enable=0: ignored.
- ones_cnt never exceeds STUFF_LEN and never wraps.
- rst during any state: immediate return to the reset values above; an in-flight strobe is lost.

Optional Feature:
NRZI_RX_STUFF_CNT_EN
- Defined: adds output port stuff_count[7:0]. It increments on every stuff_drop, saturates at 255, and clears on an EOP sample and on rst. Counting is unaffected by the ERR state.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset, then the level sequence 1,0,0,1 with each sample strobed (IDLE_LEVEL=1) -> bit_valid pulses 4x, bit_out = 1,0,1,0, each one cycle after its strobe.
- Seven constant-level samples (six 1s), then one level toggle -> six valid 1s, then stuff_drop=1 with bit_valid=0; the next sample decodes normally.
- Six 1s, then a seventh constant-level sample -> stuff_err pulse and rx_err_hold=1; later samples give bit_valid=0; an EOP sample clears rx_err_hold.
- EOP sample mid-run after three 1s -> ones_cnt reset; the next packet needs six fresh 1s before stuffing is expected; prev_lvl returns to 1.
- rst asserted asynchronously between clock edges while in STUFF -> all outputs 0 immediately; the following six 1s are required again before a stuff bit is expected.
- With NRZI_RX_STUFF_CNT_EN: 3 stuffed bits in one packet -> stuff_count=3; an EOP sample -> 0; 300 stuffs -> stuff_count=255.

Source files
------------

// File: rtl/nrzi_rx_unstuff.sv
// USB receive NRZI decoder with bit unstuffing and stuff-error detection.
// Optional macro NRZI_RX_STUFF_CNT_EN adds a saturating stuffed-bit counter output.
module nrzi_rx_unstuff #(
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       shift_enable,
    input  logic       eop,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       stuff_drop,
    output logic       stuff_err,
    output logic       rx_err_hold
`ifdef NRZI_RX_STUFF_CNT_EN
    ,
    output logic [7:0] stuff_count
`endif
);

    typedef enum logic [1:0] {S_RUN, S_STUFF, S_ERR} state_t;

    state_t             r_state, w_state_n;
    logic               r_prev, w_prev_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               r_bit, w_bit_n;
    logic               r_vld, w_vld_n;
    logic               r_drop, w_drop_n;
    logic               r_err, w_err_n;
    logic               r_hold, w_hold_n;

    logic w_acc, w_eop_s, w_dec;

    assign w_acc   = shift_enable & ~eop;
    assign w_eop_s = shift_enable & eop;
    // No transition on the line decodes as a 1.
    assign w_dec   = (d_plus == r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_prev  <= IDLE_LEVEL;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_vld   <= 1'b0;
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_prev  <= w_prev_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_vld   <= w_vld_n;
            r_drop  <= w_drop_n;
            r_err   <= w_err_n;
            r_hold  <= w_hold_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_prev_n  = r_prev;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_vld_n   = 1'b0;
        w_drop_n  = 1'b0;
        w_err_n   = 1'b0;
        w_hold_n  = r_hold;
        if (w_eop_s) begin
            w_prev_n  = IDLE_LEVEL;
            w_cnt_n   = '0;
            w_state_n = S_RUN;
            w_hold_n  = 1'b0;
        end else if (w_acc) begin
            w_prev_n = d_plus;
            case (r_state)
                S_RUN: begin
                    w_bit_n = w_dec;
                    w_vld_n = 1'b1;
                    if (!w_dec) begin
                        w_cnt_n = '0;
                    end else if (r_cnt == CNT_W'(STUFF_LEN - 1)) begin
                        w_cnt_n   = CNT_W'(STUFF_LEN);
                        w_state_n = S_STUFF;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
                S_STUFF: begin
                    if (!w_dec) begin
                        w_drop_n  = 1'b1;
                        w_cnt_n   = '0;
                        w_state_n = S_RUN;
                    end else begin
                        w_err_n   = 1'b1;
                        w_hold_n  = 1'b1;
                        w_state_n = S_ERR;
                    end
                end
                // Packet is already corrupt: track the line but emit nothing until EOP.
                S_ERR: begin
                    w_cnt_n = '0;
                end
                default: begin
                    w_state_n = S_RUN;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    assign bit_out     = r_bit;
    assign bit_valid   = r_vld;
    assign stuff_drop  = r_drop;
    assign stuff_err   = r_err;
    assign rx_err_hold = r_hold;

`ifdef NRZI_RX_STUFF_CNT_EN
    logic [7:0] r_scnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_scnt <= 8'd0;
        else if (w_eop_s)
            r_scnt <= 8'd0;
        else if (w_drop_n && r_scnt != 8'hFF)
            r_scnt <= r_scnt + 8'd1;
    end

    assign stuff_count = r_scnt;
`endif

endmodule

// File: tb/tb_nrzi_rx_unstuff.sv
// Scoreboard bench for nrzi_rx_unstuff: directed line levels with hand-decoded expectations.
module tb_nrzi_rx_unstuff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_plus = 1'b1;
    logic shift_enable = 1'b0;
    logic eop = 1'b0;
    logic bit_out, bit_valid, stuff_drop, stuff_err, rx_err_hold;
`ifdef NRZI_RX_STUFF_CNT_EN
    logic [7:0] stuff_count;
`endif

    nrzi_rx_unstuff dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus       (d_plus),
        .shift_enable (shift_enable),
        .eop          (eop),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .stuff_drop   (stuff_drop),
        .stuff_err    (stuff_err),
        .rx_err_hold  (rx_err_hold)
`ifdef NRZI_RX_STUFF_CNT_EN
        ,
        .stuff_count  (stuff_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic b;
        logic d;
        logic e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    localparam int N  = 0;  // no output expected
    localparam int V0 = 1;
    localparam int V1 = 2;
    localparam int DR = 3;
    localparam int ER = 4;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int code);
        exp_t e;
        e = '0;
        case (code)
            V0: e.v = 1'b1;
            V1: begin e.v = 1'b1; e.b = 1'b1; end
            DR: e.d = 1'b1;
            ER: e.e = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // One strobed sample; expected response queued first.
    task automatic s(input logic lvl, input logic e, input int code);
        if (code != N) q.push_back(mk(code));
        @(negedge clk);
        d_plus = lvl;
        eop = e;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        eop = 1'b0;
    endtask

    // Six 1s at constant level p followed by a stuffed 0 (level toggle).
    task automatic stuff_seq(input logic p, output logic pn);
        for (int i = 0; i < 6; i++) s(p, 1'b0, V1);
        s(~p, 1'b0, DR);
        pn = ~p;
    endtask

    always @(negedge clk) begin
        exp_t a, e;
        if (!rst && (bit_valid || stuff_drop || stuff_err)) begin
            a = '{v: bit_valid, b: bit_valid & bit_out, d: stuff_drop, e: stuff_err};
            if (q.size() == 0) begin
                chk("unexpected_strobe", int'(a), 0);
            end else begin
                e = q.pop_front();
                chk("strobe_vs_scoreboard", int'(a), int'(e));
            end
        end
    end

    initial begin
        logic p;
        #12;
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_outputs", {bit_out, stuff_drop, stuff_err, rx_err_hold}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Levels 1,0,0,1 from idle J -> 1,0,1,0
        s(1, 0, V1); s(0, 0, V0); s(0, 0, V1); s(1, 0, V0);

        // Transition then six 1s, stuffed 0, then normal decoding resumes
        s(0, 0, V0);
        for (int i = 0; i < 6; i++) s(0, 0, V1);
        s(1, 0, DR);
        s(1, 0, V1);
        s(0, 0, V0);

        // Six 1s then a seventh 1 -> stuff error, silence until EOP
        for (int i = 0; i < 6; i++) s(0, 0, V1);
        chk("hold_before_err", rx_err_hold, 0);
        s(0, 0, ER);
        chk("hold_after_err", rx_err_hold, 1);
        s(1, 0, N); s(0, 0, N); s(0, 0, N);
        chk("hold_in_err", rx_err_hold, 1);
        s(0, 1, N);
        chk("hold_cleared_eop", rx_err_hold, 0);

        // eop without shift_enable must not reset the run
        s(1, 0, V1); s(1, 0, V1); s(1, 0, V1);
        @(negedge clk); eop = 1'b1;
        @(negedge clk); eop = 1'b0;
        s(1, 0, V1); s(1, 0, V1); s(1, 0, V1);
        s(0, 0, DR);

        // EOP after three 1s: fresh six 1s needed, prev level back to J
        s(0, 0, V1); s(0, 0, V1); s(0, 0, V1);
        s(0, 1, N);
        for (int i = 0; i < 6; i++) s(1, 0, V1);
        s(0, 0, DR);
        s(0, 1, N);

        // Async reset while a stuff bit is pending
        for (int i = 0; i < 5; i++) s(1, 0, V1);
        @(negedge clk);
        d_plus = 1'b1;
        shift_enable = 1'b1;
        @(posedge clk);
        #2;
        chk("bv_before_rst", bit_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", bit_valid, 0);
        chk("rst_async_others", {bit_out, stuff_drop, stuff_err, rx_err_hold}, 0);
        rst = 1'b0;
        @(negedge clk);
        shift_enable = 1'b0;
        for (int i = 0; i < 6; i++) s(1, 0, V1);
        s(0, 0, DR);
        s(0, 1, N);

`ifdef NRZI_RX_STUFF_CNT_EN
        chk("cnt_after_eop", stuff_count, 0);
        p = 1'b1;
        for (int i = 0; i < 3; i++) stuff_seq(p, p);
        chk("cnt_three", stuff_count, 3);
        s(p, 1, N);
        chk("cnt_eop_clear", stuff_count, 0);
        p = 1'b1;
        for (int i = 0; i < 300; i++) stuff_seq(p, p);
        chk("cnt_saturate", stuff_count, 255);
        s(p, 1, N);
`else
        p = 1'b1;
        stuff_seq(p, p);
        s(p, 1, N);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
